// File: rtl/des_block_tx_sequencer.sv
// des_block_tx_sequencer: serializes a 64-bit DES block MSB-first into UART start/busy transactions, optional CR/LF trailer.
module des_block_tx_sequencer #(
  parameter bit APPEND_CRLF = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        block_valid,
  input  logic [63:0] block_data,
  output logic        block_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        seq_busy,
  output logic        seq_done
);
  typedef enum logic [2:0] {IDLE, WAIT_IDLE, WAIT_ACK, WAIT_DONE, DONE} state_t;
  localparam logic [3:0] LAST = APPEND_CRLF ? 4'd9 : 4'd7;
  state_t state, state_n;
  logic [3:0] idx, idx_n;
  logic [63:0] shift, shift_n;
  logic [7:0] cur_byte, data_n;
  logic ready_n, start_n, busy_n, done_n;
  assign cur_byte = idx == 4'd8 ? 8'h0D : idx == 4'd9 ? 8'h0A : shift[63:56];
  always_comb begin
    state_n = state;
    idx_n = idx;
    shift_n = shift;
    ready_n = block_ready;
    start_n = 1'b0;
    data_n = tx_data;
    busy_n = seq_busy;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        busy_n = block_valid && block_ready;
        if (block_valid && block_ready) begin
          shift_n = block_data;
          idx_n = 4'd0;
          ready_n = 1'b0;
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: if (!tx_busy) begin
        start_n = 1'b1;
        data_n = cur_byte;
        state_n = WAIT_ACK;
      end
      WAIT_ACK: state_n = tx_busy ? WAIT_DONE : WAIT_ACK;
      WAIT_DONE: if (!tx_busy) begin
        if (idx == LAST) state_n = DONE;
        else begin
          idx_n = idx + 4'd1;
          shift_n = {shift[55:0], 8'h00};
          state_n = WAIT_IDLE;
        end
      end
      DONE: begin
        // seq_busy stays high through the seq_done cycle and drops in IDLE
        done_n = 1'b1;
        ready_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= 4'd0;
      shift <= 64'd0;
      block_ready <= 1'b1;
      tx_start <= 1'b0;
      tx_data <= 8'h00;
      seq_busy <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      shift <= shift_n;
      block_ready <= ready_n;
      tx_start <= start_n;
      tx_data <= data_n;
      seq_busy <= busy_n;
      seq_done <= done_n;
    end
  end
endmodule

// File: tb/tb_des_block_tx_sequencer.sv
// tb_des_block_tx_sequencer: randomized block traffic through a behavioural UART model, checked against a byte-stream reference.
module tb_des_block_tx_sequencer;
  localparam int FRAME = 160;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] valid = 2'b00, ready, start, sbusy, done, tx_busy;
  logic [1:0] ubusy = 2'b00, ext_busy = 2'b00, stuck = 2'b00, pstart = 2'b00;
  logic [63:0] bd [2];
  logic [7:0] txd [2];
  logic [7:0] held [2];
  int ucnt [2];
  int starts [2], werr [2], dones [2], rviol [2], serr [2];
  logic [7:0] cap0 [$];
  logic [7:0] cap1 [$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  assign tx_busy = ubusy | ext_busy;

  des_block_tx_sequencer #(.APPEND_CRLF(1'b0)) dut0 (
    .clk(clk), .reset(reset), .block_valid(valid[0]), .block_data(bd[0]), .block_ready(ready[0]),
    .tx_start(start[0]), .tx_data(txd[0]), .tx_busy(tx_busy[0]), .seq_busy(sbusy[0]), .seq_done(done[0]));
  des_block_tx_sequencer #(.APPEND_CRLF(1'b1)) dut1 (
    .clk(clk), .reset(reset), .block_valid(valid[1]), .block_data(bd[1]), .block_ready(ready[1]),
    .tx_start(start[1]), .tx_data(txd[1]), .tx_busy(tx_busy[1]), .seq_busy(sbusy[1]), .seq_done(done[1]));

  // UART: busy rises the cycle after start is seen and holds for one frame; reset does not recall a byte in flight
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ubusy[g]) begin
        if (ucnt[g] == 1) ubusy[g] <= 1'b0;
        ucnt[g] <= ucnt[g] - 1;
      end else if (start[g] && !tx_busy[g] && !stuck[g]) begin
        ubusy[g] <= 1'b1;
        ucnt[g] <= FRAME;
        held[g] <= txd[g];
        if (g == 0) cap0.push_back(txd[g]);
        else cap1.push_back(txd[g]);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 2; g++) begin
      if (start[g]) starts[g] <= starts[g] + 1;
      if (start[g] && pstart[g]) werr[g] <= werr[g] + 1;
      pstart[g] <= start[g];
      if (done[g]) dones[g] <= dones[g] + 1;
      if (ready[g] && sbusy[g] && !done[g]) rviol[g] <= rviol[g] + 1;
      if (ubusy[g] && txd[g] !== held[g]) serr[g] <= serr[g] + 1;
    end
  end

  function automatic logic [7:0] exp_byte(input logic [63:0] d, input int i);
    return i < 8 ? 8'((d >> (56 - 8 * i)) & 64'hFF) : (i == 8 ? 8'h0D : 8'h0A);
  endfunction

  function automatic int cap_size(input int g);
    return g == 0 ? cap0.size() : cap1.size();
  endfunction

  function automatic logic [7:0] cap_at(input int g, input int i);
    return g == 0 ? cap0[i] : cap1[i];
  endfunction

  // index of the first byte differing from the reference stream of block d, or -1
  function automatic int first_bad(input int g, input int base, input logic [63:0] d);
    for (int i = 0; i < (g == 1 ? 10 : 8); i++)
      if (cap_at(g, base + i) !== exp_byte(d, i)) return i;
    return -1;
  endfunction

  task automatic accept(input int g, input logic [63:0] d, input bit keep);
    int n = 0;
    valid[g] = 1'b1;
    bd[g] = d;
    while (!ready[g] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ready[g]) begin
      failures++;
      $display("FAIL accept_timeout dut%0d block_ready=%b required 1", g, ready[g]);
    end
    @(negedge clk);
    if (!keep) valid[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int snap);
    int n = 0;
    while (dones[g] == snap && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dones[g] == snap) begin
      failures++;
      $display("FAIL done_timeout dut%0d seq_done_count=%0d required %0d", g, dones[g], snap + 1);
    end
  endtask

  task automatic test_reset;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({ready[g], start[g], txd[g], sbusy[g], done[g]} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset dut%0d ready=%b start=%b data=%h busy=%b done=%b required 1 0 00 0 0",
                 g, ready[g], start[g], txd[g], sbusy[g], done[g]);
      end
    end
  endtask

  task automatic run_blocks(input int g, input string name, input logic [63:0] first, input int nrand);
    for (int k = 0; k <= nrand; k++) begin
      logic [63:0] d = k == 0 ? first : {$urandom, $urandom};
      int base = cap_size(g), s0 = starts[g], d0 = dones[g], bad;
      int nb = g == 1 ? 10 : 8;
      accept(g, d, 1'b0);
      wait_done(g, d0);
      bad = first_bad(g, base, d);
      checks++;
      if (cap_size(g) - base != nb || bad != -1) begin
        failures++;
        $display("FAIL %s_bytes block=%h got_count=%0d first_bad_index=%0d required count=%0d no mismatches",
                 name, d, cap_size(g) - base, bad, nb);
      end
      checks++;
      if (starts[g] - s0 != nb || dones[g] - d0 != 1) begin
        failures++;
        $display("FAIL %s_pulses starts=%0d dones=%0d required %0d 1", name, starts[g] - s0, dones[g] - d0, nb);
      end
    end
    checks++;
    if (werr[g] != 0 || serr[g] != 0 || rviol[g] != 0) begin
      failures++;
      $display("FAIL %s_protocol wide_starts=%0d data_changes=%0d ready_while_busy=%0d required 0 0 0",
               name, werr[g], serr[g], rviol[g]);
    end
  endtask

  task automatic test_basic;
    run_blocks(0, "basic", 64'h0123456789ABCDEF, 3);
  endtask

  task automatic test_crlf;
    run_blocks(1, "crlf", 64'hFFFFFFFF00000000, 2);
  endtask

  task automatic test_back_to_back;
    logic [63:0] a = {$urandom, $urandom}, b = 64'hDEADBEEFCAFEF00D;
    int base = cap_size(0), d0 = dones[0], ba, bb;
    accept(0, a, 1'b1);
    bd[0] = b;
    accept(0, b, 1'b0);
    checks++;
    if (dones[0] - d0 != 1) begin
      failures++;
      $display("FAIL b2b_order dones_before_second_accept=%0d required 1", dones[0] - d0);
    end
    wait_done(0, d0 + 1);
    ba = first_bad(0, base, a);
    bb = first_bad(0, base + 8, b);
    checks++;
    if (cap_size(0) - base != 16 || ba != -1 || bb != -1) begin
      failures++;
      $display("FAIL b2b_bytes count=%0d bad_a=%0d bad_b=%0d required 16 -1 -1", cap_size(0) - base, ba, bb);
    end
    checks++;
    if (rviol[0] != 0) begin
      failures++;
      $display("FAIL b2b_ready ready_while_busy=%0d required 0", rviol[0]);
    end
  endtask

  task automatic test_busy_at_accept;
    logic [63:0] d = {$urandom, $urandom};
    int s0 = starts[0], d0 = dones[0], base = cap_size(0), bad;
    ext_busy[0] = 1'b1;
    accept(0, d, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (starts[0] != s0) begin
      failures++;
      $display("FAIL busy_hold starts=%0d required 0", starts[0] - s0);
    end
    ext_busy[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (start[0] !== 1'b1) begin
      failures++;
      $display("FAIL busy_release tx_start=%b required 1", start[0]);
    end
    wait_done(0, d0);
    bad = first_bad(0, base, d);
    checks++;
    if (bad != -1) begin
      failures++;
      $display("FAIL busy_bytes first_bad_index=%0d required -1", bad);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] d = {$urandom, $urandom};
    int base = cap_size(0), d0, n = 0, bad;
    accept(0, d, 1'b0);
    while (!(cap_size(0) == base + 4 && ubusy[0]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready[0], sbusy[0], start[0], txd[0]} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL midreset_state ready=%b busy=%b start=%b data=%h required 1 0 0 00",
               ready[0], sbusy[0], start[0], txd[0]);
    end
    reset = 1'b0;
    d0 = dones[0];
    repeat (400) @(negedge clk);
    checks++;
    if (cap_size(0) != base + 4 || dones[0] != d0) begin
      failures++;
      $display("FAIL midreset_quiet bytes=%0d dones=%0d required 4 0", cap_size(0) - base, dones[0] - d0);
    end
    d = {$urandom, $urandom};
    base = cap_size(0);
    accept(0, d, 1'b0);
    wait_done(0, d0);
    bad = first_bad(0, base, d);
    checks++;
    if (cap_size(0) - base != 8 || bad != -1) begin
      failures++;
      $display("FAIL midreset_recover count=%0d first_bad_index=%0d required 8 -1", cap_size(0) - base, bad);
    end
  endtask

  task automatic test_stuck_ack;
    int s0 = starts[0], d0 = dones[0];
    stuck[0] = 1'b1;
    accept(0, {$urandom, $urandom}, 1'b0);
    repeat (1000) @(negedge clk);
    checks++;
    if (starts[0] - s0 != 1 || sbusy[0] !== 1'b1 || ready[0] !== 1'b0 || dones[0] != d0) begin
      failures++;
      $display("FAIL stuck_hold starts=%0d busy=%b ready=%b dones=%0d required 1 1 0 0",
               starts[0] - s0, sbusy[0], ready[0], dones[0] - d0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stuck[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ready[0] !== 1'b1 || sbusy[0] !== 1'b0) begin
      failures++;
      $display("FAIL stuck_recover ready=%b busy=%b required 1 0", ready[0], sbusy[0]);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      bd[g] = 64'd0;
      ucnt[g] = 0;
      held[g] = 8'h00;
      starts[g] = 0;
      werr[g] = 0;
      dones[g] = 0;
      rviol[g] = 0;
      serr[g] = 0;
    end
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_basic;
    test_crlf;
    test_back_to_back;
    test_busy_at_accept;
    test_reset_mid;
    test_stuck_ack;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
